// File: rtl/regfile_wr_ctrl_pkg.sv
// Shared constants, types and helpers for the register-bank write-port controller.
package regfile_wr_ctrl_pkg;

  localparam int NUM_REGS   = 8;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wr_fifo2.sv
// Two-entry in-order request buffer of {addr, data}; push ignored when full, pop when empty.
module regfile_wr_fifo2
  import regfile_wr_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  wr_req_t push_req,
  input  logic    pop,
  output wr_req_t head,
  output logic    full,
  output logic    empty
);

  wr_req_t    mem [FIFO_DEPTH];
  logic       wr_ptr, rd_ptr;
  logic [1:0] count;
  logic       push_ok, pop_ok;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_req;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Write-port controller for the 8x8 enabled-register bank: buffers writes and
// runs a one-register-per-cycle clear sequence that takes priority over them.
module regfile_wr_ctrl
  import regfile_wr_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic                clr_start,
  output logic                busy,
  output logic                clr_done,
  output logic [NUM_REGS-1:0] we,
  output logic [DATA_W-1:0]   wr_data
);

  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REGS-1:0] we_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic                clr_done_d;
  logic                push, pop, full, empty;
  wr_req_t             head, push_req;

  // Ready depends only on occupancy so it never combinationally tracks pop.
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign push_req  = '{addr: req_addr, data: req_data};
  assign busy      = (state_q == CLEAR);

  regfile_wr_fifo2 u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = '0;
    wr_data_d  = wr_data;
    clr_done_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (!empty) begin
          pop       = 1'b1;
          we_d      = onehot(head.addr);
          wr_data_d = head.data;
        end
      end
      CLEAR: begin
        we_d      = onehot(cnt_q);
        wr_data_d = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d    = IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we       <= '0;
      wr_data  <= '0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we       <= we_d;
      wr_data  <= wr_data_d;
      clr_done <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Self-checking bench: directed vector table, hand sequences for clear corners,
// and randomized traffic against a queue-based reference model.
module tb_regfile_wr_ctrl;

  logic       clk, reset_n;
  logic       req_valid, req_ready, clr_start, busy, clr_done;
  logic [2:0] req_addr;
  logic [7:0] req_data, we, wr_data;

  int errors = 0;
  int checks = 0;

  regfile_wr_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_done  (clr_done),
    .we        (we),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the downstream bank.
  logic [7:0] bank [8];
  logic       preload;
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (preload) bank[i] <= 8'hF0 + 8'(i);
      else if (we[i]) bank[i] <= wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       c;
    logic [7:0] e_we;
    logic [7:0] e_wd;
    logic       e_rdy;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl [16];

  task automatic setv(input int i, input logic v, input logic [2:0] a, input logic [7:0] d,
                      input logic c, input logic [7:0] ew, input logic [7:0] ed,
                      input logic er, input logic eb, input logic edn);
    tbl[i] = '{v, a, d, c, ew, ed, er, eb, edn};
  endtask

  // Reference model: pending writes as a queue, clear as a count of remaining writes.
  logic [10:0] mq [$];
  int          clr_left, clr_idx;
  logic [7:0]  m_we, m_data;
  logic        m_done;

  task automatic model_step();
    logic        acc;
    logic [10:0] e;
    acc    = req_valid && (mq.size() < 2);
    m_done = 1'b0;
    if (clr_left > 0) begin
      m_we   = 8'(1 << clr_idx);
      m_data = 8'h00;
      clr_idx++;
      clr_left--;
      m_done = (clr_left == 0);
    end else if (clr_start) begin
      clr_left = 8;
      clr_idx  = 0;
      m_we     = 8'h00;
    end else if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_we   = 8'(1 << e[10:8]);
      m_data = e[7:0];
    end else begin
      m_we = 8'h00;
    end
    if (acc) mq.push_back({req_addr, req_data});
  endtask

  initial begin
    logic [7:0] exp_bank [8];
    int         nbusy;
    bit         hit;

    reset_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_data = '0; clr_start = 1'b0;
    #1;
    chk("reset_we", we, 8'h00);
    chk("reset_wr_data", wr_data, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_clr_done", clr_done, 1'b0);
    chk("reset_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1; preload = 1'b0;

    // Single write, then a clear that stalls three queued writes.
    setv(0,  1, 3, 8'hA5, 0, 8'h00, 8'h00, 1, 0, 0);
    setv(1,  0, 0, 8'h00, 0, 8'h08, 8'hA5, 1, 0, 0);
    setv(2,  0, 0, 8'h00, 0, 8'h00, 8'hA5, 1, 0, 0);
    setv(3,  1, 1, 8'h11, 1, 8'h00, 8'hA5, 1, 1, 0);
    setv(4,  1, 2, 8'h22, 0, 8'h01, 8'h00, 0, 1, 0);
    setv(5,  1, 5, 8'h55, 0, 8'h02, 8'h00, 0, 1, 0);
    setv(6,  1, 5, 8'h55, 0, 8'h04, 8'h00, 0, 1, 0);
    setv(7,  1, 5, 8'h55, 0, 8'h08, 8'h00, 0, 1, 0);
    setv(8,  1, 5, 8'h55, 0, 8'h10, 8'h00, 0, 1, 0);
    setv(9,  1, 5, 8'h55, 0, 8'h20, 8'h00, 0, 1, 0);
    setv(10, 1, 5, 8'h55, 0, 8'h40, 8'h00, 0, 1, 0);
    setv(11, 1, 5, 8'h55, 1, 8'h80, 8'h00, 0, 0, 1);
    setv(12, 1, 5, 8'h55, 0, 8'h02, 8'h11, 1, 0, 0);
    setv(13, 1, 5, 8'h55, 0, 8'h04, 8'h22, 1, 0, 0);
    setv(14, 0, 0, 8'h00, 0, 8'h20, 8'h55, 1, 0, 0);
    setv(15, 0, 0, 8'h00, 0, 8'h00, 8'h55, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_valid = tbl[i].v; req_addr = tbl[i].a; req_data = tbl[i].d; clr_start = tbl[i].c;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_we", i), we, tbl[i].e_we);
      chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].e_wd);
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_clr_done", i), clr_done, tbl[i].e_done);
      if (i == 2) chk("bank_reg3", bank[3], 8'hA5);
    end
    @(negedge clk);
    req_valid = 1'b0; clr_start = 1'b0;
    for (int i = 0; i < 8; i++) exp_bank[i] = 8'h00;
    exp_bank[1] = 8'h11; exp_bank[2] = 8'h22; exp_bank[5] = 8'h55;
    for (int i = 0; i < 8; i++) chk($sformatf("bank_after_clear%0d", i), bank[i], exp_bank[i]);

    // Pending write arriving with the clear must land after it.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd6; req_data = 8'h66; clr_start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid = 1'b0; clr_start = 1'b0;
    nbusy = 1;
    hit   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (!busy) begin hit = 1'b1; break; end
      nbusy++;
    end
    chk("pend_busy_fell", hit, 1'b1);
    chk("pend_busy_cycles", nbusy, 8);
    chk("pend_done_we", {clr_done, we}, {1'b1, 8'h80});
    @(posedge clk); #1;
    chk("pend_we", we, 8'h40);
    chk("pend_wr_data", wr_data, 8'h66);
    @(posedge clk); #1;
    chk("pend_bank_reg6", bank[6], 8'h66);

    // Reset in the middle of a clear with a full FIFO.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 3'd4; req_data = 8'h44; clr_start = 1'b1;
    @(negedge clk);
    req_addr = 3'd7; req_data = 8'h77; clr_start = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (we == 8'h08) begin hit = 1'b1; break; end
    end
    chk("midclr_reached_we08", hit, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midclr_we", we, 8'h00);
    chk("midclr_wr_data", wr_data, 8'h00);
    chk("midclr_busy", busy, 1'b0);
    chk("midclr_clr_done", clr_done, 1'b0);
    chk("midclr_ready", req_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset%0d", k), {we, wr_data, busy, req_ready}, {8'h00, 8'h00, 1'b0, 1'b1});
    end

    // Randomized traffic against the reference model, starting from the idle/empty state.
    mq.delete(); clr_left = 0; clr_idx = 0; m_we = 8'h00; m_data = 8'h00; m_done = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 3'($urandom_range(0, 7));
      req_data  = 8'($urandom_range(0, 255));
      clr_start = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand%0d", k), {we, wr_data, busy, clr_done, req_ready},
          {m_we, m_data, 1'(clr_left > 0), m_done, 1'(mq.size() < 2)});
      chk($sformatf("rand%0d_onehot0", k), $onehot0(we), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_ctrl.md
Name: regfile_wr_ctrl

Overview:
- Write-port controller directly upstream of the 8 x 8-bit enabled-register bank.
- Accepts write requests over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the bank's per-register enables (one-hot) and shared data input.
- Also runs a clear sequence that zeroes all registers on command, one register per cycle.

Parameters:
- NUM_REGS, 8, number of registers in the bank (one enable bit each).
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width; log2(NUM_REGS).
- FIFO_DEPTH, 2, request buffer depth.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  write request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_addr  input  ADDR_W  target register index.
- req_data  input  DATA_W  write data.
- clr_start  input  1  start the clear sequence; sampled only in IDLE.
- busy  output  1  clear sequence in progress.
- clr_done  output  1  one-cycle pulse when the final clear write is presented.
- we  output  NUM_REGS  one-hot register enables to the bank (en of each register).
- wr_data  output  DATA_W  data to the bank's shared d_in.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO empties; state = IDLE; clear counter = 0.
  - we = 0, wr_data = 0, busy = 0, clr_done = 0.
  - req_ready = 1 once the FIFO is empty.
- Handshake:
  - req_ready = !fifo_full (combinational from count only, never from pop).
  - A push occurs on a rising edge where req_valid && req_ready.
  - Push and pop in the same cycle are legal at count 1; count is unchanged.
  - No push when full, even if a pop occurs that cycle.
- FIFO: 2 entries, each {addr, data}, in-order. Pointers wrap modulo 2.
- States: IDLE, CLEAR.
- IDLE:
  - If clr_start=1, go to CLEAR with cnt=0, busy<=1, and no pop. Clear has priority over pending writes.
  - Otherwise, if the FIFO is non-empty, pop the head and register we<=onehot(addr) and wr_data<=data.
  - Otherwise we<=0 (wr_data holds its value).
- CLEAR, each edge:
  - we<=onehot(cnt), wr_data<=0, cnt<=cnt+1.
  - When cnt==NUM_REGS-1: state<=IDLE, busy<=0, clr_done<=1.
  - clr_done is otherwise 0.
  - clr_start is ignored in CLEAR.
  - The FIFO still accepts pushes up to full but does not pop. Entries drain after the clear, so writes survive it.
- Latency: we and wr_data are registered outputs.
  - A request pushed at edge N into an empty FIFO in IDLE appears on we/wr_data in the cycle after edge N+1.
  - The bank captures it at edge N+2.
- Sustained throughput: one write per cycle.
- Clear timing: clr_start sampled at edge E0; busy is high from E0 to E8.
  - we[k] is high for the single cycle after edge E(k+1).
  - clr_done is high together with we[NUM_REGS-1].
- we is always one-hot or zero; never multi-hot.
- reset_n asserted mid-clear or mid-drain aborts immediately: buffered requests are lost and outputs return to reset values.

Decomposition:
- Shared package: NUM_REGS, DATA_W, ADDR_W constants; state enumeration {IDLE, CLEAR}; one-hot decode function.
- One sub-module: regfile_wr_fifo2, a 2-entry FIFO of {addr, data} with push/pop/full/empty and asynchronous active-low reset.

Test Plan:
- Reset: hold reset_n low mid-operation -> we=0x00, wr_data=0x00, busy=0, clr_done=0, req_ready=1 immediately, without waiting for a clock edge.
- Single write: push addr=3, data=0xA5 at edge N -> we=0x08, wr_data=0xA5 for exactly one cycle after edge N+1; bank reg3 reads 0xA5 after edge N+2.
- Back-pressure: hold req_valid with the bank consuming; then stall with a pending clear -> after 2 pushes req_ready=0 and a third request is held; order preserved. Test sequence: writes 1:0x11, 2:0x22, 5:0x55 emerge as we 0x02, 0x04, 0x20 in that order.
- Clear: bank preloaded with nonzero values, pulse clr_start -> we walks 0x01..0x80 on 8 consecutive cycles with wr_data=0x00; clr_done is a single pulse with we=0x80; busy is high for exactly 8 cycles; all registers read 0x00.
- Clear vs pending: FIFO holds {6, 0x66} when clr_start arrives -> the clear runs first, then we=0x40 / 0x66 one cycle after busy falls; reg6 ends at 0x66.
- Reset mid-clear: assert reset_n low after we=0x08 -> we, busy and the FIFO clear at once; after release, no residual writes occur and req_ready=1.
